// File: rtl/priority_encoder_8_to_3_if.sv
// Request/code bundle for the priority encoder: request lines, presented code
// with valid/ready handshake, and the pending/overrun status vectors.
interface priority_encoder_8_to_3_if #(
   parameter int N      = 8,
   parameter int CODE_W = 3
);
   logic [N-1:0]      in_lines;
   logic [CODE_W-1:0] out_code;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      pending_vec;
   logic [N-1:0]      overrun;
   logic              ovr_clr;

   // master: the encoder itself; slave: the request sources and code consumer
   modport master (
      input  in_lines, out_ready, ovr_clr,
      output out_code, out_valid, pending_vec, overrun
   );

   modport slave (
      output in_lines, out_ready, ovr_clr,
      input  out_code, out_valid, pending_vec, overrun
   );
endinterface

// File: rtl/priority_encoder_8_to_3.sv
// Sticky request collector that presents the highest pending line index as a
// binary code, one code per valid/ready handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing presented; waits for any bit in the pending register
// PRESENT | out_code valid and held until accepted; reloads back-to-back
module priority_encoder_8_to_3 #(
   parameter int N      = 8,
   parameter int CODE_W = 3,
   parameter int EDGE   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   priority_encoder_8_to_3_if.master    bus
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t            state_q, state_next;
   logic [N-1:0]      in_q;
   logic [N-1:0]      pending_q, pending_next;
   logic [N-1:0]      overrun_q, overrun_next;
   logic [CODE_W-1:0] code_q, code_next;
   logic              valid_q, valid_next;
   logic [N-1:0]      set_vec, clr_vec, ovr_set;
   logic              acc;

   function automatic logic [CODE_W-1:0] top_index(input logic [N-1:0] v);
      top_index = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) top_index = CODE_W'(i);
      end
   endfunction

   always_comb begin
      set_vec = (EDGE != 0) ? (bus.in_lines & ~in_q) : bus.in_lines;
      acc     = valid_q & bus.out_ready;
      clr_vec = acc ? (N'(1) << code_q) : '0;
      // a line set in the same cycle its code is accepted stays pending
      pending_next = (pending_q & ~clr_vec) | set_vec;
      ovr_set      = set_vec & pending_q & ~clr_vec;
      overrun_next = (overrun_q & ~{N{bus.ovr_clr}}) | ovr_set;
   end

   always_comb begin
      state_next = state_q;
      code_next  = code_q;
      valid_next = valid_q;
      unique case (state_q)
         IDLE: begin
            valid_next = 1'b0;
            if (pending_q != '0) begin
               code_next  = top_index(pending_q);
               valid_next = 1'b1;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            valid_next = 1'b1;
            if (acc) begin
               if (pending_next != '0) begin
                  code_next = top_index(pending_next);
               end else begin
                  valid_next = 1'b0;
                  state_next = IDLE;
               end
            end
         end
         default: begin
            valid_next = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         in_q      <= '0;
         pending_q <= '0;
         overrun_q <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_next;
         in_q      <= bus.in_lines;
         pending_q <= pending_next;
         overrun_q <= overrun_next;
         code_q    <= code_next;
         valid_q   <= valid_next;
      end
   end

   assign bus.out_code    = code_q;
   assign bus.out_valid   = valid_q;
   assign bus.pending_vec = pending_q;
   assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_priority_encoder_8_to_3.sv
// Self-checking bench: directed vector table and hand sequences on edge- and
// level-mode encoders, then random traffic against a line-by-line reference.
module tb_priority_encoder_8_to_3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   priority_encoder_8_to_3_if #(.N(8), .CODE_W(3)) bus_e ();
   priority_encoder_8_to_3_if #(.N(8), .CODE_W(3)) bus_l ();

   priority_encoder_8_to_3 #(.N(8), .CODE_W(3), .EDGE(1)) u_edge (
      .clk(clk), .rst_n(rst_n), .bus(bus_e)
   );
   priority_encoder_8_to_3 #(.N(8), .CODE_W(3), .EDGE(0)) u_level (
      .clk(clk), .rst_n(rst_n), .bus(bus_l)
   );

   typedef struct {
      logic [7:0] lines;
      logic       rdy;
      logic       clr;
      logic       vld;
      logic [2:0] code;
      logic [7:0] pend;
      logic [7:0] ovr;
   } vec_t;

   vec_t tbl[$];
   int checks = 0;
   int errors = 0;

   // reference state per instance (0 = edge mode, 1 = level mode)
   logic [7:0] m_pend [2];
   logic [7:0] m_ovr  [2];
   logic [7:0] m_prev [2];
   bit         m_valid[2];
   int         m_code [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [7:0] lines, input logic rdy, input logic clr,
                      input logic vld, input logic [2:0] code,
                      input logic [7:0] pend, input logic [7:0] ovr);
      vec_t v;
      v.lines = lines; v.rdy = rdy; v.clr = clr;
      v.vld = vld; v.code = code; v.pend = pend; v.ovr = ovr;
      tbl.push_back(v);
   endtask

   task automatic drive(input int u, input logic [7:0] lines, input logic rdy, input logic clr);
      if (u == 0) begin
         bus_e.in_lines = lines; bus_e.out_ready = rdy; bus_e.ovr_clr = clr;
      end else begin
         bus_l.in_lines = lines; bus_l.out_ready = rdy; bus_l.ovr_clr = clr;
      end
   endtask

   task automatic expect_out(input int u, input string tag, input logic vld,
                             input logic [2:0] code, input logic [7:0] pend,
                             input logic [7:0] ovr);
      logic       a_vld;
      logic [2:0] a_code;
      logic [7:0] a_pend, a_ovr;
      if (u == 0) begin
         a_vld = bus_e.out_valid; a_code = bus_e.out_code;
         a_pend = bus_e.pending_vec; a_ovr = bus_e.overrun;
      end else begin
         a_vld = bus_l.out_valid; a_code = bus_l.out_code;
         a_pend = bus_l.pending_vec; a_ovr = bus_l.overrun;
      end
      chk({tag, " out_valid"}, 32'(a_vld), 32'(vld));
      if (vld) chk({tag, " out_code"}, 32'(a_code), 32'(code));
      chk({tag, " pending_vec"}, 32'(a_pend), 32'(pend));
      chk({tag, " overrun"}, 32'(a_ovr), 32'(ovr));
   endtask

   function automatic int top_of(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   // one clock edge of the reference, given the inputs sampled at that edge
   task automatic model_step(input int u, input logic [7:0] lines, input bit rdy,
                             input bit clr, input bit edge_mode);
      logic [7:0] np, no;
      bit acc, rise, cleared;
      acc = m_valid[u] && rdy;
      np  = m_pend[u];
      no  = clr ? 8'h00 : m_ovr[u];
      for (int i = 0; i < 8; i++) begin
         rise    = edge_mode ? (lines[i] && !m_prev[u][i]) : lines[i];
         cleared = acc && (m_code[u] == i);
         if (rise && m_pend[u][i] && !cleared) no[i] = 1'b1;
         np[i] = rise || (m_pend[u][i] && !cleared);
      end
      if (!m_valid[u]) begin
         if (m_pend[u] != 0) begin
            m_valid[u] = 1'b1;
            m_code[u]  = top_of(m_pend[u]);
         end
      end else if (acc) begin
         if (np != 0) m_code[u] = top_of(np);
         else         m_valid[u] = 1'b0;
      end
      m_pend[u] = np;
      m_ovr[u]  = no;
      m_prev[u] = lines;
   endtask

   initial begin
      logic [7:0] r_lines;
      bit r_rdy, r_clr;

      rst_n = 1'b0;
      drive(0, 8'h00, 1'b0, 1'b0);
      drive(1, 8'h00, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      expect_out(0, "reset_e", 1'b0, 3'd0, 8'h00, 8'h00);
      chk("reset_e out_code", 32'(bus_e.out_code), 32'd0);
      expect_out(1, "reset_l", 1'b0, 3'd0, 8'h00, 8'h00);
      rst_n = 1'b1;

      // single request
      add(8'h08,1,0, 0,0,8'h08,8'h00);
      add(8'h08,1,0, 1,3,8'h08,8'h00);
      add(8'h08,1,0, 0,0,8'h00,8'h00);
      add(8'h00,0,0, 0,0,8'h00,8'h00);
      // priority with stall, then back-to-back 5,2,0
      add(8'h25,0,0, 0,0,8'h25,8'h00);
      add(8'h25,0,0, 1,5,8'h25,8'h00);
      add(8'h25,0,0, 1,5,8'h25,8'h00);
      add(8'h25,0,0, 1,5,8'h25,8'h00);
      add(8'h25,1,0, 1,2,8'h05,8'h00);
      add(8'h25,1,0, 1,0,8'h01,8'h00);
      add(8'h25,1,0, 0,0,8'h00,8'h00);
      add(8'h00,0,0, 0,0,8'h00,8'h00);
      // no preemption by line 7
      add(8'h04,0,0, 0,0,8'h04,8'h00);
      add(8'h04,0,0, 1,2,8'h04,8'h00);
      add(8'h84,0,0, 1,2,8'h84,8'h00);
      add(8'h84,0,0, 1,2,8'h84,8'h00);
      add(8'h84,1,0, 1,7,8'h80,8'h00);
      add(8'h84,1,0, 0,0,8'h00,8'h00);
      add(8'h00,0,0, 0,0,8'h00,8'h00);
      // set wins over clear on line 4
      add(8'h10,0,0, 0,0,8'h10,8'h00);
      add(8'h10,0,0, 1,4,8'h10,8'h00);
      add(8'h00,0,0, 1,4,8'h10,8'h00);
      add(8'h10,1,0, 1,4,8'h10,8'h00);
      add(8'h10,1,0, 0,0,8'h00,8'h00);
      add(8'h00,0,0, 0,0,8'h00,8'h00);
      // overrun on line 1, clear, and set winning over a coincident clear
      add(8'h02,0,0, 0,0,8'h02,8'h00);
      add(8'h00,0,0, 1,1,8'h02,8'h00);
      add(8'h02,0,0, 1,1,8'h02,8'h02);
      add(8'h02,0,0, 1,1,8'h02,8'h02);
      add(8'h02,0,1, 1,1,8'h02,8'h00);
      add(8'h00,0,0, 1,1,8'h02,8'h00);
      add(8'h02,0,1, 1,1,8'h02,8'h02);
      add(8'h00,0,1, 1,1,8'h02,8'h00);
      add(8'h00,1,0, 0,0,8'h00,8'h00);
      add(8'h00,0,0, 0,0,8'h00,8'h00);

      foreach (tbl[r]) begin
         drive(0, tbl[r].lines, tbl[r].rdy, tbl[r].clr);
         @(negedge clk);
         expect_out(0, $sformatf("vec%0d", r), tbl[r].vld, tbl[r].code, tbl[r].pend, tbl[r].ovr);
      end

      // asynchronous reset in the middle of a presentation
      drive(0, 8'h44, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      expect_out(0, "pre_rst", 1'b1, 3'd6, 8'h44, 8'h00);
      #2;
      rst_n = 1'b0;
      drive(0, 8'h00, 1'b0, 1'b0);
      #1;
      expect_out(0, "async_rst", 1'b0, 3'd0, 8'h00, 8'h00);
      chk("async_rst out_code", 32'(bus_e.out_code), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         expect_out(0, $sformatf("post_rst%0d", c), 1'b0, 3'd0, 8'h00, 8'h00);
      end

      // level mode: line 0 held high, consumer always ready
      for (int c = 0; c < 4; c++) begin
         drive(1, 8'h01, 1'b1, 1'b0);
         @(negedge clk);
         expect_out(1, $sformatf("level%0d", c), (c != 0), 3'd0, 8'h01,
                    (c == 0) ? 8'h00 : 8'h01);
      end
      drive(1, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      expect_out(1, "level_drop", 1'b0, 3'd0, 8'h00, 8'h01);
      drive(1, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      expect_out(1, "level_ovrclr", 1'b0, 3'd0, 8'h00, 8'h00);
      drive(1, 8'h00, 1'b0, 1'b0);

      // random traffic on both instances against the reference
      rst_n = 1'b0;
      drive(0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int u = 0; u < 2; u++) begin
         m_pend[u] = 8'h00; m_ovr[u] = 8'h00; m_prev[u] = 8'h00;
         m_valid[u] = 1'b0; m_code[u] = 0;
      end
      for (int c = 0; c < 1500; c++) begin
         for (int u = 0; u < 2; u++) begin
            r_lines = 8'($urandom & $urandom);
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_clr   = ($urandom_range(0, 15) == 0);
            drive(u, r_lines, r_rdy, r_clr);
            model_step(u, r_lines, r_rdy, r_clr, (u == 0));
         end
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            expect_out(u, $sformatf("rand%0d_u%0d", c, u), m_valid[u],
                       3'(m_code[u]), m_pend[u], m_ovr[u]);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
